alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Upstream command stage for the 4x8 memory-mapped ALU.
- Accepts one ALU request (A, B, op) on a valid/ready handshake.
- Issues the memory-bus write sequence A→addr0, B→addr1, op→addr2, execute→addr3.
- Captures the registered 16-bit result, clears execute, and returns the result on a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 2, memory address width; must be ≥2.
- DATA_WIDTH, 8, operand width and memory data width.
- RES_WIDTH, 16, ALU result width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_a  in  DATA_WIDTH  operand A.
- req_b  in  DATA_WIDTH  operand B.
- req_op  in  3  0=zero, 1=add, 2=sub, 3=mul, 4=div, 5-7 invalid.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_res  out  RES_WIDTH  result.
- rsp_err  out  1  invalid op (or div-by-zero, see feature).
- mem_enable  out  1  bus cycle strobe, registered.
- mem_rd_wr  out  1  1=read, 0=write; this block only writes, so it drives 0.
- mem_addr  out  ADDR_WIDTH  bus address, registered.
- mem_wr_data  out  DATA_WIDTH  bus write data, registered.
- mem_res_out  in  RES_WIDTH  registered ALU result from the memory block.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (rst low, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_res=0, rsp_err=0, mem_enable=0, mem_rd_wr=0, mem_addr=0, mem_wr_data=0, busy=0.
- Request latch:
  - Handshake is req_valid&&req_ready at edge E0.
  - req_a, req_b and req_op are latched at E0.
  - The request inputs are ignored until the sequencer returns to IDLE.
- Valid op (0-4), state sequence:
  - IDLE → WR_A: bus drives addr0/A; the memory samples it at E1.
  - WR_B: addr1/B, sampled at E2.
  - WR_OP: addr2/{5'b0,op}, sampled at E3.
  - WR_EXE: addr3/8'h01, sampled at E4.
  - WAIT: enable=0; the memory's result register updates at E5.
  - CLR: addr3/8'h00, sampled at E6. At the same E6 edge, mem_res_out is captured into rsp_res with rsp_err=0.
  - RESP: rsp_valid=1 from the cycle after E6.
- Latency: 6 clocks from acceptance to rsp_valid.
- Write width rule: zero-extend or truncate each value to DATA_WIDTH.
- Invalid op (5-7): IDLE → RESP directly. No bus cycles. rsp_res=0, rsp_err=1. Latency 1 clock.
- Response handshake:
  - RESP holds rsp_valid, rsp_res and rsp_err stable until rsp_ready is sampled high.
  - It then returns to IDLE; req_ready rises the following cycle. No back-to-back accept in the same cycle as response completion.
- mem_enable is high for exactly one clock per bus write and low in IDLE, WAIT and RESP.
- Reset asserted mid-sequence aborts immediately to reset values. Memory contents may be left with execute=1; the next command overwrites all four registers.
- rsp_ready high while rsp_valid=0 is ignored. req_valid may drop without acceptance with no effect.
- Arithmetic is not performed here: the result is passed through unmodified, including 16'hDEAD for divide by zero.

Optional Feature:
- Macro ALU_SEQ_DIV0_CHECK_EN.
- Defined: op=4 with b=0 takes IDLE → RESP directly with no bus cycles; rsp_res=16'hDEAD, rsp_err=1, latency 1.
- Undefined: op=4 with b=0 runs the full sequence; rsp_res is whatever the memory block returns (16'hDEAD) and rsp_err=0.

Decomposition:
- Package alu_seq_pkg holds:
  - Op code enum (OP_ZERO..OP_DIV).
  - Address constants ADDR_A=0, ADDR_B=1, ADDR_OP=2, ADDR_EXE=3.
  - DIV0_RESULT=16'hDEAD.
  - State enum (IDLE, WR_A, WR_B, WR_OP, WR_EXE, WAIT, CLR, RESP).
- Single module; no sub-module is needed.

Test Plan:
- Add: A=8'h12, B=8'h34, op=1 → bus writes 0:12, 1:34, 2:01, 3:01, 3:00 in order; rsp_res=16'h0046, rsp_err=0, rsp_valid exactly 6 clocks after accept.
- Mul with backpressure: A=8'hFF, B=8'hFF, op=3, rsp_ready held low 5 cycles → rsp_res=16'hFE01 held stable; req_ready stays 0 until 1 cycle after rsp handshake.
- Invalid op=6 → no mem_enable pulses; rsp_res=0, rsp_err=1 one clock after accept.
- Div by zero: A=8'h10, B=0, op=4 → without macro, full sequence and rsp_res=16'hDEAD, err=0; with ALU_SEQ_DIV0_CHECK_EN, no bus cycles and rsp_res=16'hDEAD, err=1.
- Reset mid-op: assert rst low asynchronously during WR_OP → all outputs at reset values immediately; after release, sub A=8'h05, B=8'h03 (op=2) gives rsp_res=16'h0002.
- Back-to-back: sub 8'h03-8'h05 then div 8'h64/8'h07 → rsp_res 16'hFFFE then 16'h000E; no overlap of bus sequences.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: op codes, the memory
// map of the 4x8 memory-mapped ALU, the divide-by-zero marker and the
// sequencer state encoding.
package alu_seq_pkg;

    // ALU operation codes; 5..7 are not defined and are rejected.
    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4
    } op_e;

    // Register map of the memory-mapped ALU.
    localparam int unsigned ADDR_A   = 0;
    localparam int unsigned ADDR_B   = 1;
    localparam int unsigned ADDR_OP  = 2;
    localparam int unsigned ADDR_EXE = 3;

    // Values written to the execute register.
    localparam int unsigned EXE_SET = 1;
    localparam int unsigned EXE_CLR = 0;

    // Result the ALU reports for a divide by zero.
    localparam logic [15:0] DIV0_RESULT = 16'hDEAD;

    // Sequencer states, in bus-sequence order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_A   = 3'd1,
        WR_B   = 3'd2,
        WR_OP  = 3'd3,
        WR_EXE = 3'd4,
        WAIT   = 3'd5,
        CLR    = 3'd6,
        RESP   = 3'd7
    } state_e;

    // True for op codes the ALU understands.
    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= 3'(OP_DIV);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Upstream command stage for the 4x8 memory-mapped ALU. Accepts one request
// (A, B, op), writes A, B, op and execute to the ALU's registers, waits for
// the registered result, clears execute and returns the result on a
// valid/ready response channel.
// Optional build macro: ALU_SEQ_DIV0_CHECK_EN -- when defined, op=DIV with
// B=0 is answered locally (16'hDEAD, error) without touching the bus.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic [2:0]            req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RES_WIDTH-1:0]  rsp_res,
    output logic                  rsp_err,
    output logic                  mem_enable,
    output logic                  mem_rd_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [RES_WIDTH-1:0]  mem_res_out,
    output logic                  busy
);

    state_e                r_state;
    state_e                w_next_state;
    logic [DATA_WIDTH-1:0] r_b;
    logic [2:0]            r_op;

    logic                  r_mem_enable;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wr_data;
    logic                  w_mem_enable;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wr_data;

    logic                  r_rsp_valid;
    logic [RES_WIDTH-1:0]  r_rsp_res;
    logic                  r_rsp_err;

    logic                  w_req_bad;
    logic [RES_WIDTH-1:0]  w_req_res;

    // Decide whether an incoming request is answered locally without bus cycles.
    always_comb begin
        w_req_bad = !op_is_valid(req_op);
        w_req_res = '0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
        if (req_op == 3'(OP_DIV) && req_b == '0) begin
            w_req_bad = 1'b1;
            w_req_res = RES_WIDTH'(DIV0_RESULT);
        end
`endif
    end

    // Next state plus the bus cycle for the state being entered, so the bus
    // outputs can be registered and line up with the state that owns them.
    // NOTE: every output of this block gets a default first; any path that
    // left one unassigned would infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_mem_enable  = 1'b0;
        w_mem_addr    = '0;
        w_mem_wr_data = '0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_bad) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state  = WR_A;
                        w_mem_enable  = 1'b1;
                        w_mem_addr    = ADDR_WIDTH'(ADDR_A);
                        w_mem_wr_data = req_a;
                    end
                end
            end
            WR_A: begin
                w_next_state  = WR_B;
                w_mem_enable  = 1'b1;
                w_mem_addr    = ADDR_WIDTH'(ADDR_B);
                w_mem_wr_data = r_b;
            end
            WR_B: begin
                w_next_state  = WR_OP;
                w_mem_enable  = 1'b1;
                w_mem_addr    = ADDR_WIDTH'(ADDR_OP);
                w_mem_wr_data = DATA_WIDTH'(r_op);
            end
            WR_OP: begin
                w_next_state  = WR_EXE;
                w_mem_enable  = 1'b1;
                w_mem_addr    = ADDR_WIDTH'(ADDR_EXE);
                w_mem_wr_data = DATA_WIDTH'(EXE_SET);
            end
            WR_EXE: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                w_next_state  = CLR;
                w_mem_enable  = 1'b1;
                w_mem_addr    = ADDR_WIDTH'(ADDR_EXE);
                w_mem_wr_data = DATA_WIDTH'(EXE_CLR);
            end
            CLR: begin
                w_next_state = RESP;
            end
            RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register and registered bus outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_mem_enable  <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
        end else begin
            r_state       <= w_next_state;
            r_mem_enable  <= w_mem_enable;
            r_mem_addr    <= w_mem_addr;
            r_mem_wr_data <= w_mem_wr_data;
        end
    end

    // Latch B and op at acceptance; A goes straight onto the bus at that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_b  <= '0;
            r_op <= '0;
        end else if (r_state == IDLE && req_valid) begin
            r_b  <= req_b;
            r_op <= req_op;
        end
    end

    // Response channel: captured at the end of CLR, or preset for a locally
    // rejected request whose valid then rises one clock after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && w_req_bad) begin
                        r_rsp_res <= w_req_res;
                        r_rsp_err <= 1'b1;
                    end
                end
                CLR: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_res   <= mem_res_out;
                    r_rsp_err   <= 1'b0;
                end
                RESP: begin
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_res     = r_rsp_res;
    assign rsp_err     = r_rsp_err;
    assign mem_enable  = r_mem_enable;
    assign mem_rd_wr   = 1'b0;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed, table-driven bench for alu_cmd_sequencer. A behavioural model of
// the 4x8 memory-mapped ALU answers the bus; bus writes are logged and
// checked for order and timing against each vector.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [2:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_res;
    logic        rsp_err;
    logic        mem_enable;
    logic        mem_rd_wr;
    logic [1:0]  mem_addr;
    logic [7:0]  mem_wr_data;
    logic [15:0] mem_res_out;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .RES_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_res     (rsp_res),
        .rsp_err     (rsp_err),
        .mem_enable  (mem_enable),
        .mem_rd_wr   (mem_rd_wr),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_res_out (mem_res_out),
        .busy        (busy)
    );

    // Memory-mapped ALU model: registers at 0..3, result register recomputed
    // on every clock while execute (addr 3, bit 0) is set.
    logic [7:0]  m_reg [4];
    logic [15:0] m_res;

    function automatic logic [15:0] alu(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] op);
        case (op)
            8'd0:    return 16'h0000;
            8'd1:    return {8'h00, a} + {8'h00, b};
            8'd2:    return {8'h00, a} - {8'h00, b};
            8'd3:    return {8'h00, a} * {8'h00, b};
            8'd4:    return (b == 8'h00) ? 16'hDEAD : {8'h00, a / b};
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_enable && !mem_rd_wr) m_reg[mem_addr] <= mem_wr_data;
        if (m_reg[3][0]) m_res <= alu(m_reg[0], m_reg[1], m_reg[2]);
    end
    assign mem_res_out = m_res;

    // Bus write log, sampled mid-cycle.
    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        int         cyc;
    } bus_t;
    bus_t bus_log [$];
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_enable) bus_log.push_back('{addr: mem_addr, data: mem_wr_data, cyc: cyc});
    end

    typedef struct {
        string       name;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic [15:0] res;
        logic        err;
        int          lat;
        int          nwr;
        int          hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction: accept, measure latency, optional backpressure,
    // response handshake, then check the bus writes it produced.
    task automatic run_vec(input vec_t v);
        int          lat;
        logic        got;
        logic [7:0]  exp_data [5];
        logic [1:0]  exp_addr [5];
        int          exp_off  [5];
        @(negedge clk);
        check({v.name, " req_ready idle"}, req_ready, 1);
        bus_log.delete();
        req_valid = 1'b1;
        req_a     = v.a;
        req_b     = v.b;
        req_op    = v.op;
        rsp_ready = 1'b1;  // must be ignored while rsp_valid is low
        @(posedge clk);
        #1;
        // Keep presenting different requests; they must be ignored while busy.
        req_a  = ~v.a;
        req_b  = ~v.b;
        req_op = 3'd1;
        lat = 0;
        got = rsp_valid;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            got = rsp_valid;
        end
        rsp_ready = 1'b0;
        check({v.name, " latency"}, lat, v.lat);
        check({v.name, " rsp_res"}, rsp_res, v.res);
        check({v.name, " rsp_err"}, rsp_err, v.err);
        check({v.name, " req_ready busy"}, req_ready, 0);
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            check({v.name, " hold valid"}, rsp_valid, 1);
            check({v.name, " hold res"}, rsp_res, v.res);
            check({v.name, " hold req_ready"}, req_ready, 0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({v.name, " rsp_valid after hs"}, rsp_valid, 0);
        check({v.name, " req_ready after hs"}, req_ready, 1);
        check({v.name, " bus write count"}, bus_log.size(), v.nwr);
        if (v.nwr == 5 && bus_log.size() == 5) begin
            exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
            exp_data = '{v.a, v.b, {5'b0, v.op}, 8'h01, 8'h00};
            exp_off  = '{0, 1, 2, 3, 5};
            for (int i = 0; i < 5; i++) begin
                check($sformatf("%s wr%0d addr", v.name, i), bus_log[i].addr, exp_addr[i]);
                check($sformatf("%s wr%0d data", v.name, i), bus_log[i].data, exp_data[i]);
                check($sformatf("%s wr%0d slot", v.name, i),
                      bus_log[i].cyc - bus_log[0].cyc, exp_off[i]);
            end
        end
    endtask

    vec_t vecs [8];
    vec_t post_reset;

    initial begin
        // Global time limit so the run always ends.
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"add",   8'h12, 8'h34, 3'd1, 16'h0046, 1'b0, 6, 5, 0};
        vecs[1] = '{"mul",   8'hFF, 8'hFF, 3'd3, 16'hFE01, 1'b0, 6, 5, 5};
        vecs[2] = '{"inv6",  8'hAA, 8'h55, 3'd6, 16'h0000, 1'b1, 1, 0, 2};
`ifdef ALU_SEQ_DIV0_CHECK_EN
        vecs[3] = '{"div0",  8'h10, 8'h00, 3'd4, 16'hDEAD, 1'b1, 1, 0, 0};
`else
        vecs[3] = '{"div0",  8'h10, 8'h00, 3'd4, 16'hDEAD, 1'b0, 6, 5, 0};
`endif
        vecs[4] = '{"zero",  8'h07, 8'h09, 3'd0, 16'h0000, 1'b0, 6, 5, 0};
        vecs[5] = '{"inv7",  8'h01, 8'h02, 3'd7, 16'h0000, 1'b1, 1, 0, 0};
        vecs[6] = '{"sub",   8'h03, 8'h05, 3'd2, 16'hFFFE, 1'b0, 6, 5, 0};
        vecs[7] = '{"div",   8'h64, 8'h07, 3'd4, 16'h000E, 1'b0, 6, 5, 0};
        post_reset = '{"sub_rst", 8'h05, 8'h03, 3'd2, 16'h0002, 1'b0, 6, 5, 0};

        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_res     = 16'h0000;
        req_valid = 1'b0;
        req_a     = 8'h00;
        req_b     = 8'h00;
        req_op    = 3'd0;
        rsp_ready = 1'b0;
        rst       = 1'b0;

        // Reset state.
        #12;
        check("reset req_ready", req_ready, 1);
        check("reset busy", busy, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_res", rsp_res, 0);
        check("reset rsp_err", rsp_err, 0);
        check("reset mem_enable", mem_enable, 0);
        check("reset mem_rd_wr", mem_rd_wr, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wr_data", mem_wr_data, 0);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back table vectors.
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Asynchronous reset while the op register write is on the bus.
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 8'h77;
        req_b     = 8'h11;
        req_op    = 3'd1;
        @(posedge clk);  // E0: accept, bus shows A
        #1;
        req_valid = 1'b0;
        @(posedge clk);  // E1: WR_B
        @(posedge clk);  // E2: WR_OP
        #2;
        check("mid busy before rst", busy, 1);
        check("mid mem_addr before rst", mem_addr, 2);
        rst = 1'b0;
        #1;
        check("mid rst busy", busy, 0);
        check("mid rst req_ready", req_ready, 1);
        check("mid rst mem_enable", mem_enable, 0);
        check("mid rst mem_addr", mem_addr, 0);
        check("mid rst mem_wr_data", mem_wr_data, 0);
        check("mid rst rsp_valid", rsp_valid, 0);
        check("mid rst rsp_res", rsp_res, 0);
        check("mid rst rsp_err", rsp_err, 0);
        @(negedge clk);
        rst = 1'b1;
        run_vec(post_reset);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
